// File: rtl/fb_write_arbiter_if.sv
// ============================================================================
// Module   : fb_write_arbiter_if
// Brief    : CPU store, fill control and framebuffer memory port bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fb_write_arbiter_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [2:0]  cpu_we;
    logic [23:0] cpu_data;
    logic        cpu_ack;
    logic        cpu_err;

    logic        fill_start;
    logic [23:0] fill_color;
    logic        fill_busy;
    logic        fill_done;

    logic        mem_sel;
    logic [31:0] mem_addr;
    logic [2:0]  mem_we;
    logic [23:0] mem_qin;

    // Requester side: drives CPU/fill requests, observes responses and memory port.
    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_data, fill_start, fill_color,
        input  cpu_ack, cpu_err, fill_busy, fill_done,
        input  mem_sel, mem_addr, mem_we, mem_qin
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_data, fill_start, fill_color,
        output cpu_ack, cpu_err, fill_busy, fill_done,
        output mem_sel, mem_addr, mem_we, mem_qin
    );
endinterface

`default_nettype wire

// File: rtl/fb_write_arbiter.sv
// ============================================================================
// Module   : fb_write_arbiter
// Brief    : Round-robin share of the framebuffer write port between a CPU
//            store path and a single-colour fill engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_write_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0020_0000,
    parameter int          NUM_PIXELS = 57600,
    parameter int          CNT_W      = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fb_write_arbiter_if.slave   bus
);

    localparam logic [31:0]      c_end_addr = BASE_ADDR + 32'(NUM_PIXELS);
    localparam logic [CNT_W-1:0] c_last_ptr = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_fill_accept;
    logic             w_fill_busy;
    logic             w_fill_done;

    logic             r_last_cpu;
    logic [CNT_W-1:0] r_ptr;
    logic [23:0]      r_color;

    logic             r_mem_sel;
    logic [31:0]      r_mem_addr;
    logic [2:0]       r_mem_we;
    logic [23:0]      r_mem_qin;
    logic             r_cpu_ack;
    logic             r_cpu_err;

    logic             w_cpu_pend;
    logic             w_fill_pend;
    logic             w_grant_cpu;
    logic             w_grant_fill;
    logic             w_in_window;

    // A request whose ack is on the bus this cycle was already served.
    assign w_cpu_pend   = bus.cpu_req && !r_cpu_ack;
    assign w_fill_pend  = (r_state == ST_FILL);
    assign w_grant_cpu  = w_cpu_pend  && (!w_fill_pend || !r_last_cpu);
    assign w_grant_fill = w_fill_pend && (!w_cpu_pend  ||  r_last_cpu);
    assign w_in_window  = (bus.cpu_addr >= BASE_ADDR) && (bus.cpu_addr < c_end_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_fill_accept = 1'b0;
        w_fill_busy   = 1'b0;
        w_fill_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.fill_start) begin
                    w_state_next  = ST_FILL;
                    w_fill_accept = 1'b1;
                end
            end
            ST_FILL: begin
                w_fill_busy = 1'b1;
                if (w_grant_fill && (r_ptr == c_last_ptr)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_fill_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_cpu <= 1'b0;
            r_ptr      <= '0;
            r_color    <= '0;
            r_mem_sel  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= '0;
            r_mem_qin  <= '0;
            r_cpu_ack  <= 1'b0;
            r_cpu_err  <= 1'b0;
        end else begin
            r_mem_sel <= 1'b0;
            r_mem_we  <= '0;
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            if (w_grant_cpu) begin
                r_cpu_ack  <= 1'b1;
                r_last_cpu <= 1'b1;
                if (w_in_window) begin
                    r_mem_sel  <= 1'b1;
                    r_mem_addr <= bus.cpu_addr;
                    r_mem_we   <= bus.cpu_we;
                    r_mem_qin  <= bus.cpu_data;
                end else begin
                    r_cpu_err  <= 1'b1;
                end
            end else if (w_grant_fill) begin
                r_mem_sel  <= 1'b1;
                r_mem_addr <= BASE_ADDR + 32'(r_ptr);
                r_mem_we   <= 3'b111;
                r_mem_qin  <= r_color;
                r_last_cpu <= 1'b0;
                // Pointer parks on the last pixel; it never wraps.
                if (r_ptr != c_last_ptr) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
            if (w_fill_accept) begin
                r_color <= bus.fill_color;
                r_ptr   <= '0;
            end
        end
    end

    assign bus.mem_sel   = r_mem_sel;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_qin   = r_mem_qin;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_err   = r_cpu_err;
    assign bus.fill_busy = w_fill_busy;
    assign bus.fill_done = w_fill_done;

endmodule

`default_nettype wire

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single framebuffer write port of the HDMI controller's pixel memory between two requesters.
- Requester 1 is an external CPU store path using a req/ack handshake.
- Requester 2 is an internal fill engine that writes one colour to every pixel of the frame window.
- Sits between the CPU/test writers and the HDMI controller memory port (sel/addr/we/qin), in the clk_pix domain.

Parameters:
BASE_ADDR, 32'h0020_0000, first pixel address of the framebuffer window
NUM_PIXELS, 57600, pixel count of the window; valid addresses are BASE_ADDR .. BASE_ADDR+NUM_PIXELS-1
CNT_W, 16, width of the fill pointer; must satisfy 2^CNT_W >= NUM_PIXELS

Ports:
clk  input  1  single clock (pixel clock domain)
rst  input  1  asynchronous reset, active-high
cpu_req  input  1  CPU write request; addr/we/data stable while high until ack
cpu_addr  input  32  CPU write address
cpu_we  input  3  CPU byte-lane write enable, forwarded unchanged
cpu_data  input  24  CPU write data (RGB)
cpu_ack  output  1  1-cycle pulse: CPU transaction completed
cpu_err  output  1  1-cycle pulse with cpu_ack: address outside window, write dropped
fill_start  input  1  1-cycle pulse: start a fill
fill_color  input  24  fill colour, sampled on accepted fill_start
fill_busy  output  1  high while a fill is in progress
fill_done  output  1  1-cycle pulse after the last fill write is issued
mem_sel  output  1  memory write strobe to HDMI controller
mem_addr  output  32  memory address
mem_we  output  3  memory byte-lane enables
mem_qin  output  24  memory write data

Behaviour:
- Reset (async, rst=1): all outputs 0; fill FSM returns to IDLE; fill pointer = 0; last_grant = FILL, so CPU wins the first contention.
- Reset mid-fill: the fill is abandoned, no fill_done is issued, and any in-flight mem_sel drops immediately.
- All mem_* outputs and cpu_ack/cpu_err are registered. A grant in cycle N produces mem_sel/ack in cycle N+1.
- Pending CPU request: cpu_req=1 and no cpu_ack in the current cycle. This prevents double-granting a held request.
- Back-to-back CPU transactions: if cpu_req stays high in the cycle after cpu_ack, it is a new transaction. Maximum CPU throughput is 1 write per 2 cycles.
- Pending fill request: FSM in FILL.
- Arbitration (round-robin), evaluated every cycle:
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last.
  - last_grant updates on every grant.
- CPU grant with address in window:
  - Next cycle: mem_sel=1, mem_addr=cpu_addr, mem_we=cpu_we, mem_qin=cpu_data, cpu_ack=1, cpu_err=0.
- CPU grant with address out of window (addr < BASE_ADDR or addr >= BASE_ADDR+NUM_PIXELS):
  - Next cycle: cpu_ack=1, cpu_err=1, mem_sel=0.
  - The slot is still consumed and last_grant still updates.
- Fill grant: next cycle mem_sel=1, mem_addr=BASE_ADDR+ptr (32-bit, zero-extended ptr), mem_we=3'b111, mem_qin=latched colour; then ptr increments.
- Cycles with no grant: mem_sel=0 and mem_we=0. mem_addr and mem_qin hold their last values.
- Fill FSM:
  - IDLE: fill_start=1 latches fill_color, sets ptr=0, enters FILL, and fill_busy=1 from the next cycle.
  - FILL: a grant issued with ptr==NUM_PIXELS-1 moves the FSM to DONE.
  - DONE (1 cycle): fill_done=1 and fill_busy=0; then the FSM returns to IDLE.
  - fill_done is asserted in the same cycle as the mem_sel of the last fill write.
  - fill_start outside IDLE is ignored, including a start in the DONE cycle.
- Fill duration:
  - CPU idle: NUM_PIXELS consecutive mem_sel cycles.
  - CPU saturating: the two requesters alternate, giving at most 2*NUM_PIXELS cycles.
- cpu_req and fill_start in the same IDLE cycle: the CPU is granted this cycle; the fill competes from the next cycle.
- No address wrap: ptr never exceeds NUM_PIXELS-1.
- CPU writes may overwrite pixels during a fill. The last issued write wins; ordering follows mem_sel order.

Test Plan:
- Reset values: assert rst mid-cycle -> all outputs 0 immediately; after release the first contention grants the CPU.
- Single CPU write: cpu_req with addr=32'h0020_0010, data=24'h123456, we=3'b100 -> one cycle later mem_sel=1, addr 0x00200010, qin 0x123456, we 3'b100, cpu_ack=1.
- Out-of-range CPU write: addr=0x0020E100 (BASE+57600) -> cpu_ack=1, cpu_err=1, mem_sel=0. Also check addr=0x001FFFFF -> cpu_err=1.
- Fill alone: fill_start with colour 24'h00FF00 ->
  - exactly 57600 mem_sel pulses, addresses 0x00200000..0x0020E0FF ascending, we=3'b111;
  - fill_done pulses with the final write; fill_busy then drops.
- Contention: CPU holds cpu_req continuously during a fill ->
  - mem_sel writes alternate CPU/fill;
  - cpu_ack every 2nd cycle;
  - fill completes within 115200 cycles.
- Start ignored and reset mid-fill:
  - fill_start while busy -> ptr unchanged and no restart.
  - rst at ptr=1000 -> fill_busy=0, no fill_done; a subsequent fill_start restarts at 0x00200000.
